clk_enable_mgr: RTL and testbench
=================================

# clk_enable_mgr

Parametrised clock-enable manager that sits behind the board DLL's buffered clock. It qualifies the DLL lock indication, sequences a system reset, and generates NUM_CH phase-aligned, runtime-programmable clock-enable pulses. Downstream logic runs on one global clock and is gated by these enables instead of extra divided BUFG clocks.

## Interface
- NUM_CH, 2: number of enable channels (1..8)
- DIV_WIDTH, 8: width of each divide ratio
- DIV_INIT, 4: divide ratio loaded into every channel on RESET
- FILTER_CYCLES, 16: consecutive locked cycles required before LOCKED asserts (≥1)
- RST_HOLD, 8: cycles RST_OUT stays high after LOCKED asserts (≥1)

- CLKIN  in  1  single clock, already DLL-buffered
- RESET  in  1  asynchronous, active-high; clears all state
- LOCKED_IN  in  1  raw DLL lock indication
- DIV_WE  in  1  divide-ratio write strobe, sampled each edge
- DIV_SEL  in  max(1,clog2(NUM_CH))  target channel
- DIV_VAL  in  DIV_WIDTH  new ratio; 0 and 1 both mean enable every cycle
- DIV_ACK  out  NUM_CH  one-cycle pulse per channel when a written ratio takes effect
- CE  out  NUM_CH  clock-enable pulses
- LOCKED  out  1  filtered lock
- RST_OUT  out  1  synchronous system reset, active-high

## Operation
- lock_s: LOCKED_IN after the optional synchroniser (see Configuration).
- FSM states: WAIT_LOCK (reset state), HOLD, RUN.
- WAIT_LOCK: RST_OUT=1, LOCKED=0, CE=0. The filter counter increments while lock_s=1 and clears on any lock_s=0. When it reaches FILTER_CYCLES, go to HOLD and clear all channel counters.
- HOLD: LOCKED=1, RST_OUT=1, CE running. After RST_HOLD cycles, go to RUN. lock_s=0 returns to WAIT_LOCK.
- RUN: LOCKED=1, RST_OUT=0, CE running. lock_s=0 returns to WAIT_LOCK on the next edge: LOCKED=0, RST_OUT=1, CE=0, counters cleared, filter restarts.
- Channel i, ratio d:
  - d≤1: CE[i]=1 every running cycle.
  - Otherwise CE[i]=1 when cnt==d-1, then cnt wraps to 0.
  - All counters start at 0 on entry to HOLD, so channels are phase-aligned.
- Reconfiguration:
  - A DIV_WE with DIV_SEL<NUM_CH latches DIV_VAL as that channel's pending ratio.
  - Running channel: the pending ratio loads at the edge ending that channel's next CE cycle, and cnt restarts at 0.
  - Channel not running (WAIT_LOCK): the ratio loads at the next edge.
  - DIV_ACK[i] pulses in the cycle after the load.
  - A second write before the load overwrites the pending ratio; only one ACK is issued.
  - DIV_SEL≥NUM_CH is ignored, with no ACK.
  - Writes to different channels in different cycles are independent.
- Divide ratios survive lock loss and are restored to DIV_INIT only by RESET.
- RESET mid-operation: immediately WAIT_LOCK, RST_OUT=1, LOCKED=0, CE=0, DIV_ACK=0, pending writes discarded.

## Timing
- All outputs are registered.
- Reset values: RST_OUT=1, LOCKED=0, CE=0, DIV_ACK=0.
- LOCKED_IN rise to LOCKED rise: FILTER_CYCLES+2 edges with the synchroniser, FILTER_CYCLES edges without.
- LOCKED rise to RST_OUT fall: RST_HOLD edges.
- First CE[i] after LOCKED rises: at cycle d-1, where the HOLD entry cycle is cycle 0.
- LOCKED_IN fall to LOCKED fall / RST_OUT rise / CE stop: 3 edges with the synchroniser, 1 without.
- DIV_WE to DIV_ACK, channel idle: 2 edges. Running channel: the terminal CE cycle +1.

## Configuration
- CLKMGR_LOCK_SYNC_EN defined: LOCKED_IN passes through a two-flop synchroniser, reset to 0, before the FSM. Use this for an asynchronous DLL lock.
- Undefined: LOCKED_IN feeds the FSM directly. The caller guarantees it is synchronous to CLKIN. All lock latencies shrink by 2 edges.

## Test plan
Defaults, CLKMGR_LOCK_SYNC_EN defined.
- Lock-up: RESET pulse, then LOCKED_IN=1 steady. Expect LOCKED rises 18 edges later, RST_OUT falls 8 edges after that. CE[0] and CE[1] pulse together every 4th cycle, first at HOLD cycle 3.
- Lock glitch: LOCKED_IN high for 10 cycles, low for 1, then high. Expect the filter to restart, and LOCKED to rise 18 edges after the second rise.
- Reprogram running channel: in RUN, write SEL=1, VAL=2 mid-period. Expect CE[1] completes its current divide-by-4 period, then pulses every 2nd cycle. DIV_ACK[1] pulses once, the cycle after the switching CE. CE[0] is unaffected.
- Overwrite and invalid select: write SEL=0 VAL=6, then SEL=0 VAL=1 the next cycle, then SEL=3. Expect a single DIV_ACK[0], then CE[0] high every cycle, and no ACK for SEL=3.
- Lock loss in RUN: drop LOCKED_IN. Expect 3 edges later LOCKED=0, RST_OUT=1, CE=0. On re-lock, channels restart phase-aligned with the reprogrammed ratios retained.
- Async reset mid-HOLD: assert RESET between edges. Expect all outputs at reset values immediately and ratios back to 4.

Source files
------------

// File: rtl/clk_enable_mgr.sv
// Clock-enable manager: DLL lock filter, system reset sequencer and NUM_CH phase-aligned,
// runtime-programmable clock enables. Define CLKMGR_LOCK_SYNC_EN to synchronise LOCKED_IN.
module clk_enable_mgr #(
    parameter int NUM_CH        = 2,
    parameter int DIV_WIDTH     = 8,
    parameter int DIV_INIT      = 4,
    parameter int FILTER_CYCLES = 16,
    parameter int RST_HOLD      = 8,
    localparam int SEL_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 CLKIN,
    input  logic                 RESET,
    input  logic                 LOCKED_IN,
    input  logic                 DIV_WE,
    input  logic [SEL_W-1:0]     DIV_SEL,
    input  logic [DIV_WIDTH-1:0] DIV_VAL,
    output logic [NUM_CH-1:0]    DIV_ACK,
    output logic [NUM_CH-1:0]    CE,
    output logic                 LOCKED,
    output logic                 RST_OUT
);

    localparam int FILT_W = $clog2(FILTER_CYCLES + 1);
    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam logic [FILT_W-1:0]    FILT_LAST = FILT_W'(FILTER_CYCLES - 1);
    localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [DIV_WIDTH-1:0] ONE       = DIV_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_HOLD      = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [FILT_W-1:0]   filt_q, filt_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                locked_q, rst_out_q;
    logic                lock_s;
    logic                running_q_s, running_d_s, enter_hold_s;

    logic [NUM_CH-1:0][DIV_WIDTH-1:0] ratio_q, ratio_d;
    logic [NUM_CH-1:0][DIV_WIDTH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0][DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0]                pend_vld_q, pend_vld_d;
    logic [NUM_CH-1:0]                ce_q, ce_d;
    logic [NUM_CH-1:0]                ack_q, ack_d;
    logic [NUM_CH-1:0]                wr_hit_s, load_s;

`ifdef CLKMGR_LOCK_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchroniser for an asynchronous DLL lock indication.
    always_ff @(posedge CLKIN or posedge RESET) begin
        if (RESET) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], LOCKED_IN};
        end
    end

    assign lock_s = sync_q[1];
`else
    assign lock_s = LOCKED_IN;
`endif

    // Lock filter, reset hold and run sequencing.
    always_comb begin
        state_d = state_q;
        filt_d  = filt_q;
        hold_d  = hold_q;
        case (state_q)
            ST_WAIT_LOCK: begin
                if (!lock_s) begin
                    filt_d = {FILT_W{1'b0}};
                end else if (filt_q == FILT_LAST) begin
                    state_d = ST_HOLD;
                    filt_d  = {FILT_W{1'b0}};
                    hold_d  = {HOLD_W{1'b0}};
                end else begin
                    filt_d = filt_q + FILT_W'(1);
                end
            end
            ST_HOLD: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    filt_d  = {FILT_W{1'b0}};
                end else if (hold_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                    hold_d  = {HOLD_W{1'b0}};
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    filt_d  = {FILT_W{1'b0}};
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
                filt_d  = {FILT_W{1'b0}};
                hold_d  = {HOLD_W{1'b0}};
            end
        endcase
    end

    assign running_q_s  = (state_q != ST_WAIT_LOCK);
    assign running_d_s  = (state_d != ST_WAIT_LOCK);
    assign enter_hold_s = (state_q == ST_WAIT_LOCK) && (state_d == ST_HOLD);

    // Sequencer state and its registered LOCKED / RST_OUT decode.
    always_ff @(posedge CLKIN or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_WAIT_LOCK;
            filt_q    <= {FILT_W{1'b0}};
            hold_q    <= {HOLD_W{1'b0}};
            locked_q  <= 1'b0;
            rst_out_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            filt_q    <= filt_d;
            hold_q    <= hold_d;
            locked_q  <= (state_d != ST_WAIT_LOCK);
            rst_out_q <= (state_d != ST_RUN);
        end
    end

    // Per-channel ratio load, divide counter and enable generation.
    always_comb begin
        ratio_d    = ratio_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        cnt_d      = cnt_q;
        ce_d       = {NUM_CH{1'b0}};
        ack_d      = {NUM_CH{1'b0}};
        wr_hit_s   = {NUM_CH{1'b0}};
        load_s     = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            // Out-of-range selects match no channel and are dropped here.
            wr_hit_s[i] = DIV_WE && (DIV_SEL == SEL_W'(i));
            // A running channel only switches ratio at the end of a CE cycle.
            load_s[i]   = pend_vld_q[i] && (!running_q_s || ce_q[i]);

            if (load_s[i]) begin
                ratio_d[i] = pend_q[i];
                ack_d[i]   = 1'b1;
            end else begin
                ratio_d[i] = ratio_q[i];
                ack_d[i]   = 1'b0;
            end

            if (wr_hit_s[i]) begin
                pend_d[i]     = DIV_VAL;
                pend_vld_d[i] = 1'b1;
            end else if (load_s[i]) begin
                pend_vld_d[i] = 1'b0;
            end else begin
                pend_vld_d[i] = pend_vld_q[i];
            end

            if (!running_d_s || enter_hold_s || load_s[i]) begin
                cnt_d[i] = {DIV_WIDTH{1'b0}};
            end else if ((ratio_q[i] <= ONE) || (cnt_q[i] >= ratio_q[i] - ONE)) begin
                cnt_d[i] = {DIV_WIDTH{1'b0}};
            end else begin
                cnt_d[i] = cnt_q[i] + ONE;
            end

            ce_d[i] = running_d_s && ((ratio_d[i] <= ONE) || (cnt_d[i] == ratio_d[i] - ONE));
        end
    end

    // Channel state registers; ratios return to DIV_INIT only on RESET.
    always_ff @(posedge CLKIN or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ratio_q[i] <= DIV_WIDTH'(DIV_INIT);
                pend_q[i]  <= {DIV_WIDTH{1'b0}};
                cnt_q[i]   <= {DIV_WIDTH{1'b0}};
            end
            pend_vld_q <= {NUM_CH{1'b0}};
            ce_q       <= {NUM_CH{1'b0}};
            ack_q      <= {NUM_CH{1'b0}};
        end else begin
            ratio_q    <= ratio_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            pend_vld_q <= pend_vld_d;
            ce_q       <= ce_d;
            ack_q      <= ack_d;
        end
    end

    assign CE      = ce_q;
    assign DIV_ACK = ack_q;
    assign LOCKED  = locked_q;
    assign RST_OUT = rst_out_q;

endmodule

// File: tb/tb_clk_enable_mgr.sv
// Directed bench for clk_enable_mgr: lock-up, glitch filter, reprogramming, lock loss, async reset.
// Three channels are used so that select value 3 lies outside the channel range.
module tb_clk_enable_mgr;
    localparam int NUM_CH    = 3;
    localparam int DIV_WIDTH = 8;
    localparam int FILT      = 16;
    localparam int HOLD      = 8;
    localparam int SEL_W     = 2;
`ifdef CLKMGR_LOCK_SYNC_EN
    localparam int SYNC_LAT  = 2;
`else
    localparam int SYNC_LAT  = 0;
`endif

    logic                 clk = 1'b0;
    logic                 RESET, LOCKED_IN, DIV_WE;
    logic [SEL_W-1:0]     DIV_SEL;
    logic [DIV_WIDTH-1:0] DIV_VAL;
    logic [NUM_CH-1:0]    DIV_ACK, CE;
    logic                 LOCKED, RST_OUT;

    int n_tests = 0;
    int n_fail  = 0;

    clk_enable_mgr #(
        .NUM_CH(NUM_CH), .DIV_WIDTH(DIV_WIDTH), .DIV_INIT(4),
        .FILTER_CYCLES(FILT), .RST_HOLD(HOLD)
    ) dut (
        .CLKIN(clk), .RESET(RESET), .LOCKED_IN(LOCKED_IN), .DIV_WE(DIV_WE),
        .DIV_SEL(DIV_SEL), .DIV_VAL(DIV_VAL), .DIV_ACK(DIV_ACK), .CE(CE),
        .LOCKED(LOCKED), .RST_OUT(RST_OUT)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected CE for phase-aligned channels, k cycles after HOLD entry.
    function automatic logic [2:0] ce_pat(input int k, input int d0, input int d1, input int d2);
        int d[3];
        logic [2:0] r;
        d = '{d0, d1, d2};
        r = 3'b000;
        for (int i = 0; i < 3; i++) begin
            r[i] = (d[i] <= 1) || ((k % d[i]) == (d[i] - 1));
        end
        return r;
    endfunction

    task automatic wait_rise(input string tag, input int exp_edges);
        int n = 0;
        logic [NUM_CH-1:0] ack_or = '0;
        while (LOCKED !== 1'b1 && n < 200) begin
            tick();
            n++;
            ack_or |= DIV_ACK;
        end
        check(tag, 32'(n), 32'(exp_edges));
        check({tag, "_no_ack"}, 32'(ack_or), 32'd0);
    endtask

    task automatic wait_fall(input string tag, input int exp_edges);
        int n = 0;
        while (LOCKED !== 1'b0 && n < 50) begin
            tick();
            n++;
        end
        check(tag, 32'(n), 32'(exp_edges));
    endtask

    initial begin
        logic [2:0] exp_ce, exp_ack;
        RESET = 1'b1; LOCKED_IN = 1'b0; DIV_WE = 1'b0; DIV_SEL = 2'd0; DIV_VAL = 8'd0;
        #1;
        check("reset_rst_out", 32'(RST_OUT), 32'd1);
        check("reset_locked",  32'(LOCKED),  32'd0);
        check("reset_ce",      32'(CE),      32'd0);
        check("reset_ack",     32'(DIV_ACK), 32'd0);
        tick(); tick();

        // Lock-up from reset with a steady lock
        RESET = 1'b0; LOCKED_IN = 1'b1;
        wait_rise("lockup_latency", FILT + SYNC_LAT);
        check("hold0_ce", 32'(CE), 32'd0);
        check("hold0_rst_out", 32'(RST_OUT), 32'd1);
        for (int k = 1; k <= 11; k++) begin
            tick();
            check("hold_ce", 32'(CE), 32'(ce_pat(k, 4, 4, 4)));
            check("hold_rst_out", 32'(RST_OUT), 32'(k < HOLD));
        end

        // Lock glitch restarts the filter
        RESET = 1'b1; LOCKED_IN = 1'b0; #2; RESET = 1'b0;
        check("glitch_reset_locked", 32'(LOCKED), 32'd0);
        LOCKED_IN = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        check("glitch_pre_locked", 32'(LOCKED), 32'd0);
        LOCKED_IN = 1'b0;
        tick();
        LOCKED_IN = 1'b1;
        wait_rise("glitch_latency", FILT + SYNC_LAT);
        for (int k = 1; k <= HOLD; k++) begin
            tick();
            check("glitch_rst_out", 32'(RST_OUT), 32'(k < HOLD));
        end

        // Reprogram channel 1 to divide-by-2 at cycle 8 (mid-period)
        DIV_WE = 1'b1; DIV_SEL = 2'd1; DIV_VAL = 8'd2;
        for (int c = 9; c <= 20; c++) begin
            tick();
            DIV_WE = 1'b0;
            exp_ce[0] = (c % 4 == 3);
            exp_ce[2] = (c % 4 == 3);
            exp_ce[1] = (c <= 11) ? (c % 4 == 3) : (c % 2 == 1);
            exp_ack   = (c == 12) ? 3'b010 : 3'b000;
            check("reprog_ce", 32'(CE), 32'(exp_ce));
            check("reprog_ack", 32'(DIV_ACK), 32'(exp_ack));
        end

        // Overwrite a pending ratio, then write an out-of-range select
        DIV_WE = 1'b1; DIV_SEL = 2'd0; DIV_VAL = 8'd6;
        for (int c = 21; c <= 30; c++) begin
            tick();
            if (c == 21) begin
                DIV_SEL = 2'd0; DIV_VAL = 8'd1;
            end else if (c == 22) begin
                DIV_SEL = 2'd3; DIV_VAL = 8'd5;
            end else begin
                DIV_WE = 1'b0;
            end
            exp_ce[0] = (c >= 23);
            exp_ce[1] = (c % 2 == 1);
            exp_ce[2] = (c % 4 == 3);
            exp_ack   = (c == 24) ? 3'b001 : 3'b000;
            check("overwrite_ce", 32'(CE), 32'(exp_ce));
            check("overwrite_ack", 32'(DIV_ACK), 32'(exp_ack));
        end

        // Lock loss in RUN, then re-lock with retained ratios
        LOCKED_IN = 1'b0;
        wait_fall("loss_latency", 1 + SYNC_LAT);
        check("loss_rst_out", 32'(RST_OUT), 32'd1);
        check("loss_ce", 32'(CE), 32'd0);
        LOCKED_IN = 1'b1;
        wait_rise("relock_latency", FILT + SYNC_LAT);
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) tick();
            check("relock_ce", 32'(CE), 32'(ce_pat(k, 1, 2, 4)));
        end

        // Async reset mid-HOLD with a write still pending on channel 2
        DIV_WE = 1'b1; DIV_SEL = 2'd2; DIV_VAL = 8'd2;
        tick();
        DIV_WE = 1'b0;
        RESET = 1'b1;
        #1;
        check("areset_rst_out", 32'(RST_OUT), 32'd1);
        check("areset_locked",  32'(LOCKED),  32'd0);
        check("areset_ce",      32'(CE),      32'd0);
        check("areset_ack",     32'(DIV_ACK), 32'd0);
        RESET = 1'b0;
        wait_rise("areset_relock", FILT + SYNC_LAT);
        for (int k = 0; k <= 7; k++) begin
            if (k > 0) tick();
            check("areset_ratio_ce", 32'(CE), 32'(ce_pat(k, 4, 4, 4)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
